// File: rtl/npc_gen_bp.sv
// -----------------------------------------------------------------------------
// npc_gen_bp -- next-PC generator with fetch PC register and direct-mapped BTB
//
// Holds the IF-stage fetch PC. It predicts the following PC from a BTB with
// 2-bit saturating direction counters. It redirects fetch for EX-stage branch
// mispredicts, EX-stage JALR and ID-stage JAL. Resolved EX branches train the
// BTB.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   en_f           fetch enable; 0 holds pc_f unless a redirect is taken
//   pc_f           current fetch PC (registered)
//   pred_taken_f   BTB predicts taken for pc_f (travels with the instruction)
//   jal_d          ID-stage JAL present; jal_target_d is its target
//   jalr_e         EX-stage JALR present; jalr_target_e is its target
//   br_e           EX-stage conditional branch resolved (one pulse per branch)
//   br_taken_e     actual outcome of that branch
//   br_pc_e        PC of that branch
//   br_target_e    computed target of that branch
//   br_pred_e      pred_taken_f value that was carried with that branch
//   redirect       fetch redirected this cycle (combinational)
//   redirect_src   00 none, 01 JAL_D, 10 JALR_E, 11 BR_MISPREDICT_E
// -----------------------------------------------------------------------------
module npc_gen_bp #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_f,
    output logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    input  logic            jal_d,
    input  logic [XLEN-1:0] jal_target_d,
    input  logic            jalr_e,
    input  logic [XLEN-1:0] jalr_target_e,
    input  logic            br_e,
    input  logic            br_taken_e,
    input  logic [XLEN-1:0] br_pc_e,
    input  logic [XLEN-1:0] br_target_e,
    input  logic            br_pred_e,
    output logic            redirect,
    output logic [1:0]      redirect_src
);

    localparam int              IDX     = $clog2(BTB_ENTRIES);
    localparam int              TAG_W   = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_JAL  = 2'b01;
    localparam logic [1:0] SRC_JALR = 2'b10;
    localparam logic [1:0] SRC_MIS  = 2'b11;

    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

    // -------------------------------------------------------------------------
    // Saturating 2-bit direction counter helpers
    // -------------------------------------------------------------------------
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // -------------------------------------------------------------------------
    // BTB storage. Only the valid bits are reset; tag/target/counter contents
    // are meaningless while the matching valid bit is clear.
    // -------------------------------------------------------------------------
    logic            btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag   [BTB_ENTRIES];
    logic [XLEN-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]      btb_ctr    [BTB_ENTRIES];

    // -------------------------------------------------------------------------
    // Lookup on the current fetch PC (combinational, sees pre-update state)
    // -------------------------------------------------------------------------
    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [XLEN-1:0]  pc_seq;
    logic [XLEN-1:0]  pred_npc;

    assign look_idx     = pc_f[IDX+1:2];
    assign look_tag     = pc_f[XLEN-1:IDX+2];
    assign look_hit     = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
    assign pred_taken_f = look_hit && btb_ctr[look_idx][1];
    assign pc_seq       = pc_f + PC_STEP;
    assign pred_npc     = pred_taken_f ? btb_target[look_idx] : pc_seq;

    // -------------------------------------------------------------------------
    // Redirect selection. A mispredicted branch outranks JALR (the two are never
    // legal together), and any EX redirect squashes the wrong-path JAL in ID.
    // A predicted-taken branch that is taken counts as correct even if its
    // target changed; the BTB target is refreshed by the update below.
    // -------------------------------------------------------------------------
    logic            mispredict;
    logic [XLEN-1:0] redirect_target;

    assign mispredict = br_e && (br_taken_e != br_pred_e);

    always_comb begin
        redirect_src    = SRC_NONE;
        redirect_target = pred_npc;
        if (mispredict) begin
            redirect_src    = SRC_MIS;
            redirect_target = br_taken_e ? br_target_e : (br_pc_e + PC_STEP);
        end else if (jalr_e) begin
            redirect_src    = SRC_JALR;
            redirect_target = jalr_target_e;
        end else if (jal_d) begin
            redirect_src    = SRC_JAL;
            redirect_target = jal_target_d;
        end
    end

    assign redirect = (redirect_src != SRC_NONE);

    // -------------------------------------------------------------------------
    // Fetch PC register. A redirect must land even during a stall, otherwise
    // the flushed instruction stream would resume at a stale address.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f <= RESET_PC;
        end else if (redirect) begin
            pc_f <= redirect_target;
        end else if (en_f) begin
            pc_f <= pred_npc;
        end
    end

    // -------------------------------------------------------------------------
    // Training from resolved EX branches (independent of stall and redirect)
    // -------------------------------------------------------------------------
    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign upd_idx = br_pc_e[IDX+1:2];
    assign upd_tag = br_pc_e[XLEN-1:IDX+2];
    assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

    // Valid only ever rises on a taken branch: a taken hit keeps it set and a
    // taken miss allocates. Not-taken branches never create or clear entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else if (br_e && br_taken_e) begin
            btb_valid[upd_idx] <= 1'b1;
        end
    end

    // Writes that happen while rst is asserted leave valid clear, so the
    // entry is still empty after reset release.
    always_ff @(posedge clk) begin
        if (br_e) begin
            if (upd_hit) begin
                if (br_taken_e) begin
                    btb_ctr[upd_idx]    <= sat_inc(btb_ctr[upd_idx]);
                    btb_target[upd_idx] <= br_target_e;
                end else begin
                    btb_ctr[upd_idx]    <= sat_dec(btb_ctr[upd_idx]);
                end
            end else if (br_taken_e) begin
                btb_tag[upd_idx]    <= upd_tag;
                btb_target[upd_idx] <= br_target_e;
                btb_ctr[upd_idx]    <= CTR_WEAK_TAKEN;
            end
        end
    end

endmodule

// File: tb/tb_npc_gen_bp.sv
// -----------------------------------------------------------------------------
// Testbench for npc_gen_bp: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the fetch PC and BTB.
// -----------------------------------------------------------------------------
module tb_npc_gen_bp;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_f;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic        jal_d;
    logic [31:0] jal_target_d;
    logic        jalr_e;
    logic [31:0] jalr_target_e;
    logic        br_e;
    logic        br_taken_e;
    logic [31:0] br_pc_e;
    logic [31:0] br_target_e;
    logic        br_pred_e;
    logic        redirect;
    logic [1:0]  redirect_src;

    always #5 clk = ~clk;

    npc_gen_bp #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .en_f          (en_f),
        .pc_f          (pc_f),
        .pred_taken_f  (pred_taken_f),
        .jal_d         (jal_d),
        .jal_target_d  (jal_target_d),
        .jalr_e        (jalr_e),
        .jalr_target_e (jalr_target_e),
        .br_e          (br_e),
        .br_taken_e    (br_taken_e),
        .br_pc_e       (br_pc_e),
        .br_target_e   (br_target_e),
        .br_pred_e     (br_pred_e),
        .redirect      (redirect),
        .redirect_src  (redirect_src)
    );

    // Reference model: BTB as a map from set number to entry; a set is valid
    // when it exists in the map. Direction strength is a plain integer 0..3.
    typedef struct {
        logic [31:0] tag;
        logic [31:0] target;
        int          strength;
    } entry_t;

    entry_t      m_btb [int];
    logic [31:0] m_pc;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic logic model_hit(input logic [31:0] pc);
        return m_btb.exists(set_of(pc)) && (m_btb[set_of(pc)].tag == tag_of(pc));
    endfunction

    // One clock cycle: apply inputs, compare combinational outputs and the
    // current PC against the model, advance the model, then clock the DUT.
    task automatic cycle(input logic en, input logic jal, input logic [31:0] jt,
                         input logic jalr, input logic [31:0] jrt,
                         input logic br, input logic bt, input logic [31:0] bpc,
                         input logic [31:0] btgt, input logic bp);
        logic        e_pred;
        logic [31:0] e_npc;
        logic [31:0] e_tgt;
        logic [1:0]  e_src;
        int          s;
        en_f = en; jal_d = jal; jal_target_d = jt; jalr_e = jalr; jalr_target_e = jrt;
        br_e = br; br_taken_e = bt; br_pc_e = bpc; br_target_e = btgt; br_pred_e = bp;
        #2;
        e_pred = model_hit(m_pc) && (m_btb[set_of(m_pc)].strength >= 2);
        e_npc  = e_pred ? m_btb[set_of(m_pc)].target : m_pc + 32'd4;
        e_src  = 2'b00;
        e_tgt  = e_npc;
        if (br && (bt != bp)) begin
            e_src = 2'b11;
            e_tgt = bt ? btgt : bpc + 32'd4;
        end else if (jalr) begin
            e_src = 2'b10;
            e_tgt = jrt;
        end else if (jal) begin
            e_src = 2'b01;
            e_tgt = jt;
        end
        chk("pc_f", pc_f, m_pc);
        chk("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, e_pred});
        chk("redirect", {31'd0, redirect}, {31'd0, e_src != 2'b00});
        chk("redirect_src", {30'd0, redirect_src}, {30'd0, e_src});
        if (e_src != 2'b00) m_pc = e_tgt;
        else if (en) m_pc = e_npc;
        if (br) begin
            s = set_of(bpc);
            if (model_hit(bpc)) begin
                if (bt) begin
                    m_btb[s].strength = (m_btb[s].strength < 3) ? m_btb[s].strength + 1 : 3;
                    m_btb[s].target   = btgt;
                end else begin
                    m_btb[s].strength = (m_btb[s].strength > 0) ? m_btb[s].strength - 1 : 0;
                end
            end else if (bt) begin
                m_btb[s] = '{tag: tag_of(bpc), target: btgt, strength: 2};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic jump(input logic [31:0] t);
        cycle(1'b1, 1'b1, t, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic branch(input logic [31:0] bpc, input logic bt, input logic [31:0] btgt, input logic bp);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, bt, bpc, btgt, bp);
    endtask

    logic [31:0] pool [8] = '{32'h0000_0040, 32'h0000_0044, 32'h0000_0080, 32'h0000_00C0,
                              32'h0000_1040, 32'h0000_0100, 32'h0000_007C, 32'hFFFF_FFFC};

    initial begin
        rst = 1'b1;
        en_f = 1'b1; jal_d = 1'b0; jal_target_d = '0; jalr_e = 1'b0; jalr_target_e = '0;
        br_e = 1'b0; br_taken_e = 1'b0; br_pc_e = '0; br_target_e = '0; br_pred_e = 1'b0;
        m_pc = 32'h0;
        #1;
        chk("reset_pc", pc_f, 32'h0);
        chk("reset_pred", {31'd0, pred_taken_f}, 32'd0);
        chk("reset_redirect", {31'd0, redirect}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Sequential fetch after reset: 0, 4, 8, 12, 16
        idle(4);
        chk("seq_pc_0x10", pc_f, 32'h10);

        // Stall holds, then a JAL redirects through the stall
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("stall_hold", pc_f, 32'h10);
        cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("jal_over_stall", pc_f, 32'h100);

        // Train taken branch at 0x40, then predict it
        branch(32'h40, 1'b1, 32'h80, 1'b0);
        chk("train_redirect_pc", pc_f, 32'h80);
        jump(32'h40);
        chk("pred_taken_at_0x40", {31'd0, pred_taken_f}, 32'd1);
        idle(1);
        chk("pred_follow_pc", pc_f, 32'h80);

        // Hysteresis: 10 -> 01 (not taken), then 11, then 10
        branch(32'h40, 1'b0, 32'h80, 1'b1);
        chk("mis_nt_pc", pc_f, 32'h44);
        jump(32'h40);
        chk("weak_nt_pred", {31'd0, pred_taken_f}, 32'd0);
        idle(1);
        branch(32'h40, 1'b1, 32'h80, 1'b0);
        branch(32'h40, 1'b1, 32'h80, 1'b1);
        branch(32'h40, 1'b0, 32'h80, 1'b1);
        jump(32'h40);
        chk("strong_then_weak_pred", {31'd0, pred_taken_f}, 32'd1);
        idle(1);

        // Priority: mispredict beats JAL; JALR beats JAL
        cycle(1'b1, 1'b1, 32'h300, 1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 32'h280, 1'b1);
        chk("mis_over_jal", pc_f, 32'h204);
        cycle(1'b1, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("jalr_over_jal", pc_f, 32'h500);

        // Aliasing: 0x80 evicts 0x40 from set 0
        branch(32'h80, 1'b1, 32'h1000, 1'b0);
        jump(32'h40);
        chk("evicted_miss", {31'd0, pred_taken_f}, 32'd0);
        idle(1);

        // Wrap at the top of the address space
        jump(32'hFFFF_FFFC);
        idle(1);
        chk("pc_wrap", pc_f, 32'h0);

        // Retrain 0x40, then async reset with a pending taken update
        branch(32'h40, 1'b1, 32'h80, 1'b0);
        idle(2);
        en_f = 1'b1; jal_d = 1'b0; jalr_e = 1'b0;
        br_e = 1'b1; br_taken_e = 1'b1; br_pc_e = 32'h40; br_target_e = 32'h900; br_pred_e = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc_f, 32'h0);
        chk("async_rst_pred", {31'd0, pred_taken_f}, 32'd0);
        m_pc = 32'h0;
        m_btb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        br_e = 1'b0;
        idle(1);
        jump(32'h40);
        chk("btb_empty_after_rst", {31'd0, pred_taken_f}, 32'd0);
        idle(1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic r_en, r_jal, r_jalr, r_br, r_bt, r_bp;
            r_en   = ($urandom_range(0, 3) != 0);
            r_jal  = ($urandom_range(0, 7) == 0);
            r_jalr = ($urandom_range(0, 9) == 0);
            r_br   = ($urandom_range(0, 2) == 0);
            r_bt   = 1'($urandom_range(0, 1));
            r_bp   = 1'($urandom_range(0, 1));
            if (r_br) r_jalr = 1'b0;
            cycle(r_en, r_jal, pool[$urandom_range(0, 7)], r_jalr, pool[$urandom_range(0, 7)],
                  r_br, r_bt, pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)], r_bp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/npc_gen_bp.md
Name: npc_gen_bp

Overview:
Next-PC generator with an integrated fetch PC register and a direct-mapped branch target buffer (BTB). It uses 2-bit saturating direction counters. It predicts the next PC for the current fetch address and redirects fetch on EX-stage branch mispredicts, EX-stage JALR and ID-stage JAL. It also trains the BTB from resolved EX-stage branches. It sits at the head of the 5-stage pipeline and drives the IF stage PC.

Parameters:
XLEN, 32, data and address width
BTB_ENTRIES, 16, number of BTB entries; power of 2, minimum 2
RESET_PC, 32'h0000_0000, value loaded into pc_f on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en_f  in  1  fetch PC enable; 0 = stall (hold pc_f)
pc_f  out  XLEN  current fetch PC (register)
pred_taken_f  out  1  BTB predicts taken for pc_f (to be piped down with the instruction)
jal_d  in  1  ID-stage JAL present
jal_target_d  in  XLEN  JAL target
jalr_e  in  1  EX-stage JALR present
jalr_target_e  in  XLEN  JALR target (LSB already cleared)
br_e  in  1  EX-stage conditional branch resolved; one-cycle pulse per branch
br_taken_e  in  1  actual branch outcome
br_pc_e  in  XLEN  PC of the EX branch
br_target_e  in  XLEN  computed branch target
br_pred_e  in  1  pred_taken_f value carried with that branch
redirect  out  1  fetch redirected this cycle; the hazard unit flushes IF/ID (and ID/EX for EX sources)
redirect_src  out  2  00 none, 01 JAL_D, 10 JALR_E, 11 BR_MISPREDICT_E

Behaviour:
- IDX = log2(BTB_ENTRIES).
  - index = pc[IDX+1:2].
  - tag = pc[XLEN-1:IDX+2].
  - Each entry holds: valid, tag, target[XLEN-1:0], ctr[1:0].
- Lookup is combinational on pc_f.
  - hit = valid && tag match.
  - pred_taken_f = hit && ctr[1].
  - pred_npc = pred_taken_f ? entry.target : pc_f+4.
- Mispredict: mis = br_e && (br_taken_e != br_pred_e). A predicted-taken, actually-taken branch is correct; the target is not re-checked.
- Next-PC priority, highest first:
  1. mis: br_taken_e ? br_target_e : br_pc_e+4; src=11.
  2. jalr_e: jalr_target_e; src=10.
  3. jal_d: jal_target_d; src=01.
  4. Otherwise pred_npc; src=00.
- redirect = (src != 00); combinational.
- pc_f update on the rising clk edge:
  - If redirect: pc_f <= selected target, regardless of en_f. A redirect overrides a stall.
  - Else if en_f: pc_f <= pred_npc.
  - Else: hold.
- br_e and jalr_e asserted together is illegal; the branch wins. An EX redirect masks jal_d (wrong path).
- All PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 = 0.
- BTB update on the rising edge when br_e=1, entry at index(br_pc_e):
  - Hit, taken: ctr = sat_inc(ctr); target <= br_target_e.
  - Hit, not taken: ctr = sat_dec(ctr); target unchanged.
  - Miss, taken: allocate, replacing any entry. valid=1, tag, target=br_target_e, ctr=2'b10.
  - Miss, not taken: no write.
  - Counters saturate at 00 and 11.
- Lookup and update to the same index in the same cycle: the lookup sees pre-update contents (no bypass).
- Update is independent of en_f and redirect.
- Reset (asynchronous):
  - pc_f=RESET_PC.
  - All valid=0; ctr, tag and target are don't-care.
  - pred_taken_f=0.
  - redirect=0 only if the redirect inputs are low.
- Reset asserted mid-operation aborts any pending update. The BTB is empty the first cycle after release.
- Latency: prediction is 0 cycles (same cycle as pc_f); BTB training is visible the cycle after br_e.
- Storage: flops, or distributed RAM with an asynchronous read. Valid bits must be flops, clearable by rst.

Test Plan:
1. Reset: rst pulse with RESET_PC=0 and en_f=1, no events -> pc_f = 0, 4, 8, 12 on successive edges; pred_taken_f=0; redirect=0.
2. Stall vs redirect: en_f=0 at pc_f=0x10 -> pc_f holds 0x10. Then jal_d=1, jal_target_d=0x100 with en_f=0 -> redirect=1, src=01, next pc_f=0x100.
3. Train and predict: br_e with br_pc_e=0x40, taken, target 0x80, br_pred_e=0 -> redirect src=11, pc_f=0x80, entry ctr=10. Later at pc_f=0x40 -> pred_taken_f=1, next pc_f=0x80, redirect=0.
4. Counter hysteresis on 0x40 (ctr=10):
   - Not taken, pred=1 -> mis, pc_f=0x44, ctr=01.
   - Next lookup at 0x40 predicts not taken.
   - Two taken resolutions -> ctr=11; one not-taken -> ctr=10, still predicts taken.
5. Priority: mis (not taken, br_pc_e=0x200) plus jal_d (target 0x300) in the same cycle -> src=11, pc_f=0x204. jalr_e (target 0x500) plus jal_d -> src=10, pc_f=0x500.
6. Aliasing and wrap:
   - BTB_ENTRIES=16: taken branches at 0x40 then 0x80 (same index 0) -> 0x80 evicts 0x40; lookup at 0x40 misses.
   - pc_f=32'hFFFF_FFFC with en_f=1 -> next pc_f=0.
   - Async rst mid-run -> pc_f=RESET_PC immediately; BTB empty.
